// File: rtl/jtag_pkg.sv
// Shared types for the JTAG TAP / debug transport block: TAP states, IR opcodes,
// DMI operation and status encodings.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE    = 5'h01;
  localparam logic [4:0] IR_DTMCS     = 5'h10;
  localparam logic [4:0] IR_DMIACCESS = 5'h11;
  localparam logic [4:0] IR_BYPASS    = 5'h1f;

  typedef enum logic [1:0] {
    DMI_NOP,
    DMI_READ,
    DMI_WRITE,
    DMI_RSVD
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_OK,
    DMI_STATUS_RSVD,
    DMI_FAILED,
    DMI_BUSY
  } dmi_status_e;

  // Status reported to the debugger: an outstanding request reads as busy
  // even before the sticky field has recorded an overrun.
  function automatic dmi_status_e dmi_status(input logic busy, input dmi_status_e sticky);
    if (busy || sticky == DMI_BUSY) return DMI_BUSY;
    else if (sticky == DMI_FAILED)  return DMI_FAILED;
    else                            return DMI_OK;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state machine stepped by tms on posedge tclk,
// with decoded capture/shift/update strobes for the IR and DR paths.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic tclk,
  input  logic trst,
  input  logic tms,
  output logic test_logic_reset,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir
);

  tap_state_e state;
  tap_state_e state_next;

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) state <= TEST_LOGIC_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_next = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    test_logic_reset = 1'b0;
    capture_dr       = 1'b0;
    shift_dr         = 1'b0;
    update_dr        = 1'b0;
    capture_ir       = 1'b0;
    shift_ir         = 1'b0;
    update_ir        = 1'b0;
    case (state)
      TEST_LOGIC_RESET: test_logic_reset = 1'b1;
      CAPTURE_DR:       capture_dr       = 1'b1;
      SHIFT_DR:         shift_dr         = 1'b1;
      UPDATE_DR:        update_dr        = 1'b1;
      CAPTURE_IR:       capture_ir       = 1'b1;
      SHIFT_IR:         shift_ir         = 1'b1;
      UPDATE_IR:        update_ir        = 1'b1;
      default:          ;
    endcase
  end

endmodule

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP with a debug transport module: IR/DR scan chains plus the DMI
// request/response bridge to the debug module, all on tclk.
module jtag_dtm_tap
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int          IR_LEN       = 5,
  parameter int          ABITS        = 7
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic             dmi_resp_err,
  output logic             dmi_hard_reset
);

  localparam int DMI_W = ABITS + 34;
  localparam logic [IR_LEN-1:0] OP_IDCODE    = IR_LEN'(IR_IDCODE);
  localparam logic [IR_LEN-1:0] OP_DTMCS     = IR_LEN'(IR_DTMCS);
  localparam logic [IR_LEN-1:0] OP_DMIACCESS = IR_LEN'(IR_DMIACCESS);
  localparam logic [5:0]        ABITS_FIELD  = 6'(ABITS);

  logic test_logic_reset;
  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tclk             (tclk),
    .trst             (trst),
    .tms              (tms),
    .test_logic_reset (test_logic_reset),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  logic [IR_LEN-1:0] ir;
  logic [IR_LEN-1:0] ir_shift;
  logic [DMI_W-1:0]  dr_shift;
  logic [DMI_W-1:0]  dr_capture;
  logic [DMI_W-1:0]  dr_shifted;

  logic              busy, busy_next;
  dmi_status_e       sticky, sticky_next;
  dmi_status_e       status;
  logic [ABITS-1:0]  last_addr;
  logic [31:0]       resp_data_q;
  logic              accept;

  logic sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;

  always_comb begin
    sel_idcode = (ir == OP_IDCODE);
    sel_dtmcs  = (ir == OP_DTMCS);
    sel_dmi    = (ir == OP_DMIACCESS);
    sel_bypass = !(sel_idcode || sel_dtmcs || sel_dmi);
  end

  assign status = dmi_status(busy, sticky);

  always_comb begin
    dr_capture = '0;
    if (sel_dmi)
      dr_capture = {last_addr, resp_data_q, status};
    else if (sel_dtmcs)
      dr_capture = DMI_W'({14'd0, 1'b0, 1'b0, 1'b0, 3'd1, status, ABITS_FIELD, 4'd1});
    else if (sel_idcode)
      dr_capture = DMI_W'(IDCODE_VALUE);
  end

  // The shared shift register is zero-extended on capture, so a plain right
  // shift works for every length once tdi lands at that register's MSB.
  always_comb begin
    dr_shifted = dr_shift >> 1;
    if (sel_dmi)
      dr_shifted[DMI_W-1] = tdi;
    else if (sel_bypass)
      dr_shifted = {{(DMI_W-1){1'b0}}, tdi};
    else
      dr_shifted[31] = tdi;
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ir       <= OP_IDCODE;
      ir_shift <= '0;
      dr_shift <= '0;
    end else begin
      if (capture_ir)    ir_shift <= IR_LEN'(1);
      else if (shift_ir) ir_shift <= {tdi, ir_shift[IR_LEN-1:1]};

      if (test_logic_reset) ir <= OP_IDCODE;
      else if (update_ir)   ir <= ir_shift;

      if (capture_dr)    dr_shift <= dr_capture;
      else if (shift_dr) dr_shift <= dr_shifted;
    end
  end

  assign tdo_en = shift_dr | shift_ir;
  assign tdo    = shift_ir ? ir_shift[0] : (shift_dr ? dr_shift[0] : 1'b0);

  logic             dmi_update, dtmcs_update, resp_fire, hard_reset_req;
  dmi_op_e          upd_op;
  logic [31:0]      upd_data;
  logic [ABITS-1:0] upd_addr;

  assign dmi_update     = update_dr && sel_dmi;
  assign dtmcs_update   = update_dr && sel_dtmcs;
  assign hard_reset_req = dtmcs_update && dr_shift[17];
  assign resp_fire      = dmi_resp_valid && busy;
  assign upd_op         = dmi_op_e'(dr_shift[1:0]);
  assign upd_data       = dr_shift[33:2];
  assign upd_addr       = dr_shift[DMI_W-1:34];

  // Response is folded in before the Update decision so a same-cycle
  // response frees the slot for the new request.
  always_comb begin
    busy_next   = busy;
    sticky_next = sticky;
    accept      = 1'b0;
    if (resp_fire) begin
      busy_next = 1'b0;
      if (dmi_resp_err) sticky_next = DMI_FAILED;
    end
    if (dmi_update && (upd_op == DMI_READ || upd_op == DMI_WRITE)) begin
      if (sticky_next == DMI_OK) begin
        if (busy_next) begin
          sticky_next = DMI_BUSY;
        end else begin
          accept    = 1'b1;
          busy_next = 1'b1;
        end
      end
    end
    if (dtmcs_update && dr_shift[16]) sticky_next = DMI_OK;
    if (hard_reset_req) begin
      sticky_next = DMI_OK;
      busy_next   = 1'b0;
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      busy           <= 1'b0;
      sticky         <= DMI_OK;
      last_addr      <= '0;
      resp_data_q    <= '0;
      dmi_req_valid  <= 1'b0;
      dmi_req_addr   <= '0;
      dmi_req_data   <= '0;
      dmi_req_op     <= '0;
      dmi_hard_reset <= 1'b0;
    end else begin
      busy           <= busy_next;
      sticky         <= sticky_next;
      dmi_hard_reset <= hard_reset_req;
      // dmi_req_op still names the outstanding request when its response arrives
      if (resp_fire && dmi_req_op == DMI_READ) resp_data_q <= dmi_resp_data;
      if (accept) begin
        dmi_req_valid <= 1'b1;
        dmi_req_addr  <= upd_addr;
        dmi_req_data  <= upd_data;
        dmi_req_op    <= upd_op;
        last_addr     <= upd_addr;
      end else if (hard_reset_req || (dmi_req_valid && dmi_req_ready)) begin
        dmi_req_valid <= 1'b0;
      end
    end
  end

  assign dmi_resp_ready = 1'b1;

endmodule
